memory_arbiter: RTL

Shares one single-port synchronous memory between the core's instruction-fetch port and its data (memory-access stage) port. Each cycle it grants at most one requester, drives the memory address/write controls, and routes the one-cycle-latency read data back to the owner with a valid strobe. Data accesses win by default because they belong to the older instruction. A streak counter guarantees fetch progress. Non-granted requesters stall their pipeline stage on `*_gnt` low.

---
 rtl/memory_arbiter_pkg.sv | 18 +
 rtl/memory_arbiter_if.sv | 45 ++++
 rtl/memory_arbiter_sat_counter.sv | 32 +++
 rtl/memory_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
// XLEN        : core data width
// BE_W        : byte-enable width (one bit per byte of XLEN)
// owner_t     : encoding of which port owns the response in flight;
//               the values are fixed so pipeline-control logic can decode
//               equivalent owner signals elsewhere in the core.
package memory_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DATA   = 2'd2
  } owner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory port seen by the
// arbiter.
// slave  : arbiter side (takes requests and mem_rdata, returns grants,
//          read data, rvalid strobes and memory controls)
// master : core/memory side (drives requests and mem_rdata)
interface memory_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic [XLEN-1:0]   i_rdata;
  logic              i_rvalid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic [XLEN-1:0]   d_rdata;
  logic              d_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_wren;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output i_gnt, i_rdata, i_rvalid, d_gnt, d_rdata, d_rvalid,
           mem_addr, mem_wdata, mem_be, mem_wren
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  i_gnt, i_rdata, i_rvalid, d_gnt, d_rdata, d_rvalid,
           mem_addr, mem_wdata, mem_be, mem_wren
  );

endinterface

// File: rtl/memory_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear, used as a starvation guard.
// clock  : rising-edge clock
// reset  : synchronous active-high reset (count -> 0)
// inc    : increment by one, holding at MAX
// clr    : clear to zero; wins over inc
// count  : current value
// at_max : count has reached MAX
module sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == WIDTH'(MAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// the data port. Data wins contention unless it has already taken
// MAX_D_STREAK grants in a row while fetch waited, in which case fetch gets
// one slot. Read data returns one cycle after the grant with an rvalid strobe
// for the port that owned that grant.
// clock : rising-edge clock
// reset : synchronous active-high reset
// bus   : fetch port, data port and memory port (slave modport)
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int MAX_D_STREAK = 4
) (
  input  logic               clock,
  input  logic               reset,
  memory_arbiter_if.slave    bus
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  logic [STREAK_W-1:0] streak;
  logic                streak_at_max;
  logic                d_gnt_int;
  logic                i_gnt_int;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BE_W-1:0]     sel_be;
  owner_t              resp_owner;

  // Data wins unless fetch is waiting and data already used its streak.
  assign d_gnt_int = !reset && bus.d_req && (!bus.i_req || !streak_at_max);
  assign i_gnt_int = !reset && bus.i_req && (!bus.d_req || streak_at_max);

  // The streak only counts data grants that made fetch wait; any cycle
  // without a fetch request, or a fetch grant, restarts it.
  sat_counter #(
    .WIDTH (STREAK_W),
    .MAX   (MAX_D_STREAK)
  ) u_streak (
    .clock  (clock),
    .reset  (reset),
    .inc    (d_gnt_int && bus.i_req),
    .clr    (i_gnt_int || !bus.i_req),
    .count  (streak),
    .at_max (streak_at_max)
  );

  // Idle cycles still present the fetch address so the memory port never
  // floats; byte enables are zeroed unless data owns the cycle.
  assign sel_addr = d_gnt_int ? bus.d_addr : bus.i_addr;
  assign sel_be   = d_gnt_int ? bus.d_be   : '0;

  assign bus.i_gnt     = i_gnt_int;
  assign bus.d_gnt     = d_gnt_int;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_be    = sel_be;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.mem_wren  = d_gnt_int && bus.d_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
    end else if (d_gnt_int) begin
      resp_owner <= OWN_DATA;
    end else if (i_gnt_int) begin
      resp_owner <= OWN_IFETCH;
    end else begin
      resp_owner <= OWN_NONE;
    end
  end

  // Reset asserted the cycle after a grant drops that response immediately,
  // before the synchronous reset has cleared the owner register.
  assign bus.i_rvalid = !reset && (resp_owner == OWN_IFETCH);
  assign bus.d_rvalid = !reset && (resp_owner == OWN_DATA);
  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

endmodule
